// File: rtl/regfile_writeback_pkg.sv
// Shared constants and types for the register-file write-back path.
package regfile_writeback_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    StIdle,
    StWaitLoad
  } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Byte/halfword lane extraction and sign/zero extension of a raw memory word.
module load_extend
  import regfile_writeback_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    unique case (addr_lo)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ext_data = rdata;
    case (funct3)
      F3_LB:   ext_data = {{24{byte_v[7]}}, byte_v};
      F3_LH:   ext_data = {{16{half_v[15]}}, half_v};
      F3_LBU:  ext_data = {24'h000000, byte_v};
      F3_LHU:  ext_data = {16'h0000, half_v};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side sequencer: ALU results pass through, loads wait for memory, with
// registered single-cycle write pulses and a pending-load scoreboard.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [REG_ADDR_W-1:0] req_rd,
  input  logic                  req_is_load,
  input  logic [2:0]            req_funct3,
  input  logic [1:0]            req_addr_lo,
  input  logic [XLEN-1:0]       req_data,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] rd_data,
  output logic [XLEN-1:0]       write_data,
  output logic                  busy,
  output logic [REG_ADDR_W-1:0] busy_rd,
  output logic                  load_err
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  wb_state_e             state_q;
  logic [REG_ADDR_W-1:0] ld_rd_q;
  logic [2:0]            ld_f3_q;
  logic [1:0]            ld_lane_q;
  logic [7:0]            cnt_q;
  logic [XLEN-1:0]       ld_value;

  load_extend u_load_extend (
    .funct3   (ld_f3_q),
    .addr_lo  (ld_lane_q),
    .rdata    (mem_rdata),
    .ext_data (ld_value)
  );

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q == StWaitLoad);
  assign busy_rd   = busy ? ld_rd_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_lane_q  <= '0;
      cnt_q      <= '0;
      regWrite   <= 1'b0;
      rd_data    <= '0;
      write_data <= '0;
      load_err   <= 1'b0;
    end else begin
      regWrite <= 1'b0;
      load_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (req_is_load) begin
              ld_rd_q   <= req_rd;
              ld_f3_q   <= req_funct3;
              ld_lane_q <= req_addr_lo;
              cnt_q     <= '0;
              state_q   <= StWaitLoad;
            end else if (req_rd != '0) begin
              regWrite   <= 1'b1;
              rd_data    <= req_rd;
              write_data <= req_data;
            end
          end
        end
        StWaitLoad: begin
          cnt_q <= cnt_q + 8'd1;
          // Data arriving on the timeout cycle still wins over the error.
          if (mem_rvalid) begin
            state_q <= StIdle;
            if (ld_rd_q != '0) begin
              regWrite   <= 1'b1;
              rd_data    <= ld_rd_q;
              write_data <= ld_value;
            end
          end else if (cnt_q == TimeoutLast) begin
            state_q  <= StIdle;
            load_err <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench: directed cases plus random traffic against a
// transaction-level model of the write-back sequencer.
module tb_regfile_writeback;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rd;
  logic        req_is_load;
  logic [2:0]  req_funct3;
  logic [1:0]  req_addr_lo;
  logic [31:0] req_data;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        regWrite;
  logic [4:0]  rd_data;
  logic [31:0] write_data;
  logic        busy;
  logic [4:0]  busy_rd;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  // Model: at most one pending load, plus the last values written.
  bit          m_pend;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_lane;
  int          m_wait;
  logic [4:0]  m_wr_rd;
  logic [31:0] m_wr_data;
  bit          exp_we;
  bit          exp_err;

  always #5 clk = ~clk;

  regfile_writeback #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_is_load (req_is_load),
    .req_funct3  (req_funct3),
    .req_addr_lo (req_addr_lo),
    .req_data    (req_data),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .regWrite    (regWrite),
    .rd_data     (rd_data),
    .write_data  (write_data),
    .busy        (busy),
    .busy_rd     (busy_rd),
    .load_err    (load_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * int'(lane))) & 32'd255;
    h = (w >> (16 * (int'(lane) / 2))) & 32'd65535;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_rd = 0; m_f3 = 0; m_lane = 0; m_wait = 0;
    m_wr_rd = 0; m_wr_data = 0;
  endtask

  task automatic clear_inputs();
    req_valid = 0; req_is_load = 0; req_rd = 0; req_funct3 = 0;
    req_addr_lo = 0; req_data = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  // One clock with the currently driven inputs; checks before and after the edge.
  task automatic cycle();
    chk("req_ready", req_ready, !m_pend);
    chk("busy", busy, m_pend);
    chk("busy_rd", busy_rd, m_pend ? m_rd : 5'd0);
    exp_we = 0;
    exp_err = 0;
    if (!m_pend) begin
      if (req_valid && req_is_load) begin
        m_pend = 1; m_rd = req_rd; m_f3 = req_funct3; m_lane = req_addr_lo; m_wait = 0;
      end else if (req_valid && req_rd != 0) begin
        exp_we = 1; m_wr_rd = req_rd; m_wr_data = req_data;
      end
    end else begin
      m_wait++;
      if (mem_rvalid) begin
        m_pend = 0;
        if (m_rd != 0) begin
          exp_we = 1; m_wr_rd = m_rd; m_wr_data = ref_load(m_f3, m_lane, mem_rdata);
        end
      end else if (m_wait == TO) begin
        m_pend = 0; exp_err = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("regWrite", regWrite, exp_we);
    chk("rd_data", rd_data, m_wr_rd);
    chk("write_data", write_data, m_wr_data);
    chk("load_err", load_err, exp_err);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    clear_inputs();
    req_valid = 1; req_rd = rd; req_data = d;
    cycle();
    clear_inputs();
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lane);
    clear_inputs();
    req_valid = 1; req_is_load = 1; req_rd = rd; req_funct3 = f3; req_addr_lo = lane;
    req_data = 32'hA5A5_A5A5;
    cycle();
    clear_inputs();
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic mem(input logic [31:0] d);
    clear_inputs();
    mem_rvalid = 1; mem_rdata = d;
    cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regWrite", regWrite, 1'b0);
    chk("rst_rd_data", rd_data, 5'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    @(negedge clk);
    reset = 1;

    // ALU pass-through and back-to-back writes
    alu(5'd5, 32'hDEAD_BEEF);
    chk("alu_data", write_data, 32'hDEAD_BEEF);
    idle(1);
    alu(5'd1, 32'h1111_1111);
    alu(5'd2, 32'h2222_2222);
    alu(5'd3, 32'h3333_3333);
    chk("b2b_last", write_data, 32'h3333_3333);
    idle(1);

    // Byte loads, data two cycles after acceptance
    load(5'd7, 3'b000, 2'd3);
    idle(1);
    mem(32'h8011_2233);
    chk("lb_val", write_data, 32'hFFFF_FF80);
    load(5'd8, 3'b100, 2'd3);
    idle(1);
    mem(32'h8011_2233);
    chk("lbu_val", write_data, 32'h0000_0080);

    // Halfword and word loads
    load(5'd9, 3'b001, 2'd2);
    mem(32'h8001_7FFF);
    chk("lh_val", write_data, 32'hFFFF_8001);
    load(5'd10, 3'b101, 2'd2);
    mem(32'h8001_7FFF);
    chk("lhu_val", write_data, 32'h0000_8001);
    load(5'd11, 3'b010, 2'd2);
    mem(32'h8001_7FFF);
    chk("lw_val", write_data, 32'h8001_7FFF);

    // rd = 0: no writes, but the load still waits for memory
    alu(5'd0, 32'h1234_5678);
    load(5'd0, 3'b010, 2'd0);
    idle(2);
    mem(32'hCAFE_F00D);
    idle(1);

    // Timeout, stray data afterwards, then data exactly on the timeout cycle
    load(5'd12, 3'b010, 2'd0);
    idle(TO);
    chk("to_err_seen", load_err, 1'b1);
    idle(1);
    mem(32'h5555_5555);
    load(5'd13, 3'b010, 2'd0);
    idle(TO - 1);
    mem(32'h7777_7777);
    chk("to_edge_data", write_data, 32'h7777_7777);
    idle(1);

    // Reset while a load is outstanding
    load(5'd14, 3'b010, 2'd0);
    idle(1);
    reset = 0;
    #2;
    model_reset();
    chk("mid_rst_regWrite", regWrite, 1'b0);
    chk("mid_rst_rd_data", rd_data, 5'd0);
    chk("mid_rst_write_data", write_data, 32'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_busy_rd", busy_rd, 5'd0);
    chk("mid_rst_ready", req_ready, 1'b1);
    @(negedge clk);
    reset = 1;
    mem(32'h9999_9999);
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      clear_inputs();
      req_valid   = ($urandom_range(0, 3) != 0);
      req_is_load = $urandom_range(0, 1);
      req_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      req_funct3  = 3'($urandom);
      req_addr_lo = 2'($urandom);
      req_data    = $urandom;
      mem_rvalid  = ($urandom_range(0, 3) == 0);
      mem_rdata   = $urandom;
      cycle();
    end
    idle(TO + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side sequencer for the 32×32 integer register file. It accepts completed instruction results from the execute stage over a valid/ready handshake. ALU results pass straight through. For loads it waits for data memory, then extracts and extends the byte, halfword or word. It drives the register file's write port as registered, single-cycle write pulses, and exposes a busy/rd scoreboard so decode can stall on a pending load destination.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles to wait for mem_rvalid after a load is accepted; range 1..255.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents a result.
- req_ready  out  1  block can accept a request this cycle.
- req_rd  in  5  destination register index.
- req_is_load  in  1  1 = load (data comes from memory); 0 = ALU result.
- req_funct3  in  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- req_addr_lo  in  2  load address bits [1:0] (byte lane).
- req_data  in  32  ALU result; ignored for loads.
- mem_rvalid  in  1  load data valid, single-cycle pulse.
- mem_rdata  in  32  raw aligned word from data memory.
- regWrite  out  1  register-file write enable; registered.
- rd_data  out  5  register-file write index; registered.
- write_data  out  32  register-file write data; registered.
- busy  out  1  a load is outstanding.
- busy_rd  out  5  destination of the outstanding load; 0 when not busy.
- load_err  out  1  one-cycle pulse on load timeout.

## Operation
- States: IDLE, WAIT_LOAD.
- IDLE:
  - req_ready = 1.
  - On req_valid & ~req_is_load: next edge sets regWrite=1, rd_data=req_rd, write_data=req_data. Stay in IDLE.
  - On req_valid & req_is_load: capture rd, funct3 and addr_lo; clear the timeout counter; enter WAIT_LOAD. No write this cycle.
  - mem_rvalid in IDLE is ignored.
- WAIT_LOAD:
  - req_ready = 0; busy = 1; busy_rd = captured rd.
  - The counter increments every cycle.
  - On mem_rvalid: the next edge issues the write with the extracted data and returns to IDLE.
  - If the counter reaches TIMEOUT_CYCLES without mem_rvalid: return to IDLE, pulse load_err for one cycle, issue no write.
  - mem_rvalid in the same cycle as the timeout takes priority: the write is issued and there is no error.
- Extraction:
  - LB/LBU take byte mem_rdata[8*addr_lo +: 8].
  - LH/LHU take halfword mem_rdata[16*addr_lo[1] +: 16]; addr_lo[0] is ignored.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
  - LW and every undefined funct3 pass the full word.
- rd = 0 never produces a write: regWrite stays 0. The handshake and FSM behave normally otherwise (an rd=0 load still waits for memory).
- regWrite is high for exactly one cycle per write. When no write is issued, rd_data and write_data hold their last values.

## Timing
- Reset values: IDLE, regWrite=0, rd_data=0, write_data=0, busy=0, busy_rd=0, load_err=0, counter=0.
- Reset asserted mid-load aborts the load without a write. A late mem_rvalid after reset is ignored.
- ALU result: accepted at edge N; regWrite is high during cycle N+1. Throughput is one per cycle, so back-to-back writes are continuous.
- Load: accepted at edge N; busy is high from cycle N+1.
  - mem_rvalid sampled at edge M (earliest M = N+1) → regWrite high in cycle M+1, with busy=0 and req_ready=1 in the same cycle.
  - A new request can therefore be accepted at edge M+1.
- Timeout: with no mem_rvalid, load_err is high in cycle N+TIMEOUT_CYCLES+1, together with busy=0.
- req_ready is a combinational function of state only. It never depends on req_valid.

## Structure
- Shared package:
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - The state enum.
  - REG_ADDR_W=5 and XLEN=32, reused by the register file and decode.
- Sub-module load_extend: purely combinational. Inputs funct3, addr_lo, rdata; output the 32-bit extended value. It is reused later by the pipelined LSU.

## Test plan
- Reset, then an ALU request (rd=5, data=0xDEADBEEF) → regWrite=1 for one cycle with rd_data=5, write_data=0xDEADBEEF; three back-to-back ALU requests → three consecutive write cycles.
- LB load, addr_lo=3, mem_rdata=0x80112233 after 2 cycles → write_data=0xFFFFFF80; LBU in the same case → 0x00000080; busy_rd equals rd throughout the wait.
- LH load, addr_lo=2, mem_rdata=0x8001_7FFF → 0xFFFF8001; LHU → 0x00008001; LW → 0x80017FFF.
- Request with rd=0, both ALU and load → regWrite never asserts; the load still waits for mem_rvalid and returns to IDLE.
- TIMEOUT_CYCLES=4, no mem_rvalid → load_err pulses exactly once and no write occurs; a later stray mem_rvalid is ignored; mem_rvalid arriving exactly on the timeout cycle → write, no load_err.
- Assert reset in WAIT_LOAD, then deassert and pulse mem_rvalid → no write; all outputs at reset values; req_ready=1.
